// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, cause codes, command encoding and mstatus layout.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_MEI       = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI       = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI       = 32'h8000_0007;
  localparam logic [31:0] CAUSE_PLAT_BASE = 32'h8000_0010;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
  typedef enum logic [1:0] {CMD_NONE = 2'b00, CMD_RW = 2'b01, CMD_RS = 2'b10, CMD_RC = 2'b11} csr_cmd_e;
  typedef enum logic {ST_RUN = 1'b0, ST_TAKEN = 1'b1} state_e;
endpackage

// File: rtl/csr_irq_arb.sv
// csr_irq_arb: synchronises interrupt lines, masks with mie and picks the highest-priority cause.
module csr_irq_arb import csr_pkg::*; #(
  parameter int N_PLAT_IRQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ei_n_i,
  input  logic                  ti_n_i,
  input  logic                  si_n_i,
  input  logic [N_PLAT_IRQ-1:0] plat_irq_n_i,
  input  logic [31:0]           mie_i,
  input  logic                  mstatus_mie_i,
  output logic [31:0]           mip_o,
  output logic                  irq_valid_o,
  output logic [31:0]           irq_cause_o
);
  localparam int W = N_PLAT_IRQ + 3;
  logic [W-1:0] meta_q, sync_q, lvl;
  logic [31:0] pend, plat_cause;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {plat_irq_n_i, ei_n_i, ti_n_i, si_n_i};
      sync_q <= meta_q;
    end
  assign lvl = ~sync_q;
  always_comb begin
    mip_o = '0;
    mip_o[11] = lvl[2];
    mip_o[7] = lvl[1];
    mip_o[3] = lvl[0];
    mip_o[16 +: N_PLAT_IRQ] = lvl[W-1:3];
  end
  assign pend = mip_o & mie_i;
  // Scan downwards so the lowest pending platform line wins.
  always_comb begin
    plat_cause = '0;
    for (int k = N_PLAT_IRQ - 1; k >= 0; k--)
      if (pend[16+k]) plat_cause = CAUSE_PLAT_BASE + 32'(k);
  end
  assign irq_valid_o = mstatus_mie_i && (pend != '0);
  assign irq_cause_o = pend[11] ? CAUSE_MEI : pend[3] ? CAUSE_MSI : pend[7] ? CAUSE_MTI : plat_cause;
endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: machine-mode CSR file with trap/mret sequencing and a registered fetch redirect.
module csr_ctrl import csr_pkg::*; #(
  parameter int          N_PLAT_IRQ  = 4,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc,
  input  logic [1:0]            csr_cmd,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  csr_illegal,
  input  logic                  ecall,
  input  logic                  ebreak,
  input  logic                  mret,
  input  logic                  retire,
  input  logic                  ei_n,
  input  logic                  ti_n,
  input  logic                  si_n,
  input  logic [N_PLAT_IRQ-1:0] plat_irq_n,
  output logic                  trap_take,
  output logic [31:0]           trap_pc
);
  localparam logic [31:0] MIE_MASK = 32'h888 | (((32'd1 << N_PLAT_IRQ) - 32'd1) << 16);
  state_e state_q, state_d;
  logic mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, trap_pc_q, trap_pc_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] mip, irq_cause, mstatus, new_val, cause, base;
  logic irq_valid, hit, run, exc, take, do_mret, wr;
  csr_irq_arb #(.N_PLAT_IRQ(N_PLAT_IRQ)) u_arb (
    .clk(clk), .rst_n(rst_n), .ei_n_i(ei_n), .ti_n_i(ti_n), .si_n_i(si_n),
    .plat_irq_n_i(plat_irq_n), .mie_i(mie_q), .mstatus_mie_i(mie_bit_q),
    .mip_o(mip), .irq_valid_o(irq_valid), .irq_cause_o(irq_cause)
  );
  assign mstatus = MSTATUS_RST | (32'(mpie_q) << MSTATUS_MPIE) | (32'(mie_bit_q) << MSTATUS_MIE);
  always_comb begin
    rdata = '0;
    hit = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   rdata = mstatus;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       rdata = mip;
      CSR_MCYCLE:    rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   rdata = mcycle_q[63:32];
      CSR_MINSTRET:  rdata = minstret_q[31:0];
      CSR_MINSTRETH: rdata = minstret_q[63:32];
      default:       hit = 1'b0;
    endcase
  end
  assign csr_illegal = (csr_cmd != CMD_NONE) && !hit;
  assign run = state_q == ST_RUN;
  assign exc = run && (ecall || ebreak);
  assign do_mret = run && mret && !exc;
  assign take = exc || (run && !mret && irq_valid);
  assign cause = ecall ? CAUSE_ECALL : ebreak ? CAUSE_EBREAK : irq_cause;
  assign base = mtvec_q & ~32'd3;
  assign new_val = csr_cmd == CMD_RW ? wdata : csr_cmd == CMD_RS ? (rdata | wdata) : (rdata & ~wdata);
  // Trap or mret in the same slot owns the state; the CSR write is dropped.
  assign wr = run && !take && !do_mret && hit && (csr_cmd != CMD_NONE) && (csr_cmd == CMD_RW || wdata != '0);
  always_comb begin
    state_d = (take || do_mret) ? ST_TAKEN : ST_RUN;
    mie_bit_d = mie_bit_q;
    mpie_d = mpie_q;
    mie_d = mie_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    mtval_d = mtval_q;
    trap_pc_d = trap_pc_q;
    mcycle_d = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, run && retire};
    if (wr)
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_d = new_val[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE];
        end
        CSR_MIE:       mie_d = new_val & MIE_MASK;
        CSR_MTVEC:     mtvec_d = {new_val[31:2], (VECTORED_EN && new_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
        CSR_MSCRATCH:  mscratch_d = new_val;
        CSR_MEPC:      mepc_d = new_val & ~32'd3;
        CSR_MCAUSE:    mcause_d = new_val;
        CSR_MTVAL:     mtval_d = new_val;
        CSR_MCYCLE:    mcycle_d = {mcycle_q[63:32], new_val};
        CSR_MCYCLEH:   mcycle_d = {new_val, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        CSR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    if (take) begin
      mepc_d = pc & ~32'd3;
      mcause_d = cause;
      mtval_d = '0;
      mpie_d = mie_bit_q;
      mie_bit_d = 1'b0;
      trap_pc_d = (!exc && mtvec_q[1:0] == 2'b01) ? base + {25'd0, cause[4:0], 2'd0} : base;
    end else if (do_mret) begin
      mie_bit_d = mpie_q;
      mpie_d = 1'b1;
      trap_pc_d = mepc_q;
    end
    if (!COUNTERS_EN) begin
      mcycle_d = '0;
      minstret_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RUN;
      mie_bit_q <= 1'b0;
      mpie_q <= 1'b0;
      mie_q <= '0;
      mtvec_q <= RESET_VEC & ~32'd3;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      trap_pc_q <= '0;
      mcycle_q <= '0;
      minstret_q <= '0;
    end else begin
      state_q <= state_d;
      mie_bit_q <= mie_bit_d;
      mpie_q <= mpie_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
      trap_pc_q <= trap_pc_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
    end
  assign trap_take = state_q == ST_TAKEN;
  assign trap_pc = trap_pc_q;
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: scoreboarded bench; expected redirect targets are queued at stimulus and popped on trap_take.
module tb_csr_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc = 32'h2000, wdata = '0, rdata, trap_pc;
  logic [1:0] csr_cmd = 2'b00;
  logic [11:0] csr_addr = '0;
  logic csr_illegal, trap_take;
  logic ecall = 1'b0, ebreak = 1'b0, mret = 1'b0, retire = 1'b0;
  logic ei_n = 1'b1, ti_n = 1'b1, si_n = 1'b1;
  logic [3:0] plat_irq_n = 4'hF;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  csr_ctrl #(.N_PLAT_IRQ(4), .VECTORED_EN(1'b1), .RESET_VEC(32'h0), .COUNTERS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .csr_cmd(csr_cmd), .csr_addr(csr_addr), .wdata(wdata),
    .rdata(rdata), .csr_illegal(csr_illegal), .ecall(ecall), .ebreak(ebreak), .mret(mret),
    .retire(retire), .ei_n(ei_n), .ti_n(ti_n), .si_n(si_n), .plat_irq_n(plat_irq_n),
    .trap_take(trap_take), .trap_pc(trap_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag, input logic ill);
    csr_addr = a;
    csr_cmd = 2'b10;
    wdata = '0;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_illegal"}, csr_illegal, ill);
    csr_cmd = 2'b00;
  endtask
  task automatic wr(input logic [1:0] c, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_cmd = c;
    csr_addr = a;
    wdata = d;
    @(negedge clk);
    csr_cmd = 2'b00;
    wdata = '0;
  endtask
  task automatic ev(input logic e, input logic b, input logic m);
    @(negedge clk);
    ecall = e;
    ebreak = b;
    mret = m;
    @(negedge clk);
    ecall = 1'b0;
    ebreak = 1'b0;
    mret = 1'b0;
  endtask
  task automatic wait_take(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask
  always @(negedge clk)
    if (rst_n && trap_take)
      chk("trap_pc", trap_pc, exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [11:0] ra[11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB80, 12'hB02, 12'hB82};
    logic [31:0] rv[11] = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [11:0] za[7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'hB00, 12'hB02};
    logic [31:0] zv[7] = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(12'hB00, 32'd3, "rst_mcycle", 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd(ra[i], rv[i], $sformatf("rst_%0h", ra[i]), 1'b0);
    end
    @(negedge clk);
    rd(12'h7C0, 32'h0, "bad_addr", 1'b1);
    @(negedge clk);
    csr_cmd = 2'b01;
    csr_addr = 12'h344;
    wdata = '1;
    #1 chk("mip_write_illegal", csr_illegal, 0);
    @(negedge clk);
    csr_cmd = 2'b00;
    rd(12'h344, 32'h0, "mip_readonly", 1'b0);
    wr(2'b01, 12'h305, 32'h100);
    wr(2'b01, 12'h304, 32'h800);
    wr(2'b01, 12'h300, 32'h8);
    rd(12'h300, 32'h1808, "mstatus_mie_on", 1'b0);
    exp_q.push_back(32'h100);
    @(negedge clk);
    ei_n = 1'b0;
    wait_take("mei_taken", 4);
    rd(12'h342, 32'h8000_000B, "mei_mcause", 1'b0);
    rd(12'h300, 32'h1880, "mei_mstatus", 1'b0);
    rd(12'h341, 32'h2000, "mei_mepc", 1'b0);
    ei_n = 1'b1;
    repeat (3) @(negedge clk);
    wr(2'b01, 12'h305, 32'h201);
    rd(12'h305, 32'h201, "mtvec_vectored", 1'b0);
    wr(2'b01, 12'h304, 32'h0004_0080);
    @(negedge clk);
    ti_n = 1'b0;
    plat_irq_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    rd(12'h344, 32'h0004_0080, "mip_ti_plat2", 1'b0);
    exp_q.push_back(32'h21C);
    wr(2'b10, 12'h300, 32'h8);
    wait_take("mti_taken", 5);
    rd(12'h342, 32'h8000_0007, "mti_mcause", 1'b0);
    rd(12'h343, 32'h0, "mti_mtval", 1'b0);
    ti_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h248);
    ev(1'b0, 1'b0, 1'b1);
    wait_take("mret_then_plat2", 6);
    rd(12'h342, 32'h8000_0012, "plat2_mcause", 1'b0);
    plat_irq_n = 4'hF;
    repeat (3) @(negedge clk);
    pc = 32'h1002;
    exp_q.push_back(32'h200);
    ev(1'b1, 1'b0, 1'b0);
    wait_take("ecall_taken", 4);
    rd(12'h341, 32'h1000, "ecall_mepc", 1'b0);
    rd(12'h342, 32'd11, "ecall_mcause", 1'b0);
    @(negedge clk);
    rd(12'h300, 32'h1800, "ecall_mstatus", 1'b0);
    exp_q.push_back(32'h1000);
    ev(1'b0, 1'b0, 1'b1);
    wait_take("mret_taken", 4);
    rd(12'h300, 32'h1880, "mret_mstatus", 1'b0);
    pc = 32'h3000;
    exp_q.push_back(32'h200);
    ev(1'b1, 1'b0, 1'b1);
    wait_take("ecall_beats_mret", 4);
    rd(12'h341, 32'h3000, "ecall_mret_mepc", 1'b0);
    rd(12'h342, 32'd11, "ecall_mret_mcause", 1'b0);
    wr(2'b01, 12'h305, 32'h302);
    rd(12'h305, 32'h300, "mtvec_mode2", 1'b0);
    wr(2'b01, 12'h305, 32'h201);
    wr(2'b01, 12'h341, 32'h1237);
    rd(12'h341, 32'h1234, "mepc_warl", 1'b0);
    wr(2'b01, 12'h304, '1);
    rd(12'h304, 32'h000F_0888, "mie_warl", 1'b0);
    wr(2'b11, 12'h304, 32'h800);
    rd(12'h304, 32'h000F_0088, "mie_rc", 1'b0);
    wr(2'b10, 12'h304, 32'h0);
    rd(12'h304, 32'h000F_0088, "mie_rs_zero", 1'b0);
    wr(2'b01, 12'h304, 32'h0);
    wr(2'b01, 12'h300, '1);
    rd(12'h300, 32'h1888, "mstatus_warl", 1'b0);
    wr(2'b01, 12'h300, 32'h0);
    wr(2'b01, 12'h340, 32'hA5A5_0000);
    wr(2'b10, 12'h340, 32'h0000_00FF);
    wr(2'b11, 12'h340, 32'hA500_0000);
    rd(12'h340, 32'h00A5_00FF, "mscratch_rs_rc", 1'b0);
    wr(2'b01, 12'h343, 32'hCAFE);
    rd(12'h343, 32'hCAFE, "mtval_rw", 1'b0);
    @(negedge clk);
    csr_cmd = 2'b01;
    csr_addr = 12'hB00;
    wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    csr_addr = 12'hB80;
    wdata = 32'h0;
    @(negedge clk);
    csr_cmd = 2'b00;
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written", 1'b0);
    rd(12'hB80, 32'h0, "mcycleh_written", 1'b0);
    repeat (2) @(negedge clk);
    rd(12'hB00, 32'h1, "mcycle_wrap", 1'b0);
    rd(12'hB80, 32'h1, "mcycleh_carry", 1'b0);
    @(negedge clk);
    retire = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    rd(12'hB02, 32'd3, "minstret_run", 1'b0);
    exp_q.push_back(32'h200);
    @(negedge clk);
    ecall = 1'b1;
    @(negedge clk);
    ecall = 1'b0;
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    rd(12'hB02, 32'd3, "minstret_taken", 1'b0);
    rd(12'hB82, 32'd0, "minstreth", 1'b0);
    exp_q.push_back(32'h200);
    @(negedge clk);
    ebreak = 1'b1;
    csr_cmd = 2'b01;
    csr_addr = 12'h300;
    wdata = 32'h88;
    @(negedge clk);
    ebreak = 1'b0;
    csr_cmd = 2'b00;
    wdata = '0;
    rd(12'h300, 32'h1800, "ebreak_write_drop", 1'b0);
    rd(12'h342, 32'd3, "ebreak_mcause", 1'b0);
    rst_n = 1'b0;
    #1 chk("take_async_reset", trap_take, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rd(za[i], zv[i], $sformatf("reset2_%0h", za[i]), 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("take_after_reset", trap_take, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
